mem_sram_ctrl: RTL and testbench
================================

Name: mem_sram_ctrl

Overview:
- MEM-stage data-memory controller. Sits directly downstream of the EXE stage register and consumes its ALU result (address), val_Rm (store data) and mem_read/mem_write.
- Executes each 32-bit load/store as two 16-bit accesses to an external SRAM, with programmable wait states.
- Holds ready low while an access is in progress so the hazard/freeze logic stalls the pipeline.
- Returns the 32-bit load data to the MEM/WB register.

Parameters:
- SRAM_WAIT, 2, extra wait cycles per 16-bit half access; each half occupies SRAM_WAIT+1 cycles.
- ADDR_BASE, 1024, byte address mapped to SRAM word 0.
- SRAM_AW, 18, SRAM half-word address width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- rd_en  input  1  load request (mem_read from EXE register).
- wr_en  input  1  store request (mem_write from EXE register).
- address  input  32  byte address (ALU result).
- write_data  input  32  store data (val_Rm).
- read_data  output  32  load result; valid in the DONE cycle and held until the next load completes.
- ready  output  1  0 = stall the pipeline; 1 = MEM stage may advance.
- sram_addr  output  SRAM_AW  half-word address.
- sram_dq_out  output  16  write data to SRAM.
- sram_dq_oe  output  1  1 = drive sram_dq_out onto the bus.
- sram_dq_in  input  16  read data from SRAM.
- sram_ce_n, sram_oe_n, sram_we_n  output  1 each  active-low chip enable, output enable and write enable.

Behaviour:
- States: IDLE, LO, HI, DONE. A wait counter cnt counts 0..SRAM_WAIT within LO and within HI.
- IDLE:
  - ready = ~(rd_en | wr_en), combinational, so it drops in the same cycle a request appears.
  - On a request, at the clock edge: latch op (wr_en has priority if both are high), word index = (address - ADDR_BASE) >> 2 (mod 2^32), and write_data; clear cnt; go to LO.
- LO: sram_addr = {word_idx[SRAM_AW-2:0], 1'b0}; cnt increments each cycle. When cnt == SRAM_WAIT: on a read, capture sram_dq_in into read_data[15:0]; clear cnt; go to HI.
- HI: same as LO with half bit = 1. On a read, capture sram_dq_in into read_data[31:16] at cnt == SRAM_WAIT; go to DONE.
- DONE: ready = 1 for exactly one cycle; unconditionally go to IDLE. A request still asserted in DONE does not restart an access; the pipeline advances at this edge.
- Strobes in LO and HI:
  - sram_ce_n = 0.
  - Read: sram_oe_n = 0, sram_we_n = 1, sram_dq_oe = 0.
  - Write: sram_we_n = 0, sram_oe_n = 1, sram_dq_oe = 1; sram_dq_out = wdata[15:0] in LO, wdata[31:16] in HI.
- Strobes in IDLE and DONE: ce_n, oe_n, we_n = 1; dq_oe = 0; sram_addr = 0; sram_dq_out = 0.
- Latency (request first seen in cycle 0): LO occupies cycles 1..W+1, HI occupies W+2..2W+2, DONE is cycle 2W+3, where W = SRAM_WAIT. ready is low for 2W+3 cycles.
- Inputs that change after the request is latched are ignored until IDLE.
- Reset (rst = 0, any state, including mid-access):
  - Immediately: state = IDLE, cnt = 0, read_data = 0, latched op/address/data = 0; all SRAM strobes deasserted; dq_oe = 0.
  - ready = 1 while reset is held.
- A store does not modify read_data.

Decomposition:
- Shared package mem_pkg: state enum (IDLE/LO/HI/DONE), default ADDR_BASE, and SRAM half-select constants (HALF_LO = 0, HALF_HI = 1).
- No sub-module: the FSM, counter and capture registers live in one module.

Test Plan:
- Read, W = 2. SRAM model holds [4] = 0xBEEF, [5] = 0xDEAD; rd_en = 1, address = 0x408 -> ready low in cycles 0-6, high in cycle 7; sram_addr = 4 during cycles 1-3 and 5 during cycles 4-6; read_data = 0xDEADBEEF in cycle 7.
- Write, W = 2. wr_en = 1, address = 0x400, write_data = 0x12345678 -> we_n low in cycles 1-6; dq_oe = 1; dq_out = 0x5678 at addr 0 and 0x1234 at addr 1; SRAM model then holds those values; ready high in cycle 7.
- Back-to-back: read, then a write presented in the cycle after DONE -> second access starts cleanly; no extra SRAM cycle during DONE; read_data unchanged by the write.
- Reset mid-access: rst = 0 during HI of a read -> strobes high immediately, read_data = 0, ready = 1. After release, the same read reissued completes in 2W+4 cycles.
- SRAM_WAIT = 0. A read completes with ready low for 3 cycles. With rd_en = wr_en = 1, a write is performed (write priority).

Source files
------------

// File: rtl/mem_sram_ctrl_pkg.sv
// Shared definitions for the MEM-stage SRAM controller.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned ADDR_BASE_DEFAULT = 1024;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

endpackage

// File: rtl/mem_sram_ctrl.sv
// MEM-stage data-memory controller: each 32-bit load/store is split into two
// 16-bit SRAM accesses (low half first), each lasting SRAM_WAIT+1 cycles.
module mem_sram_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned SRAM_WAIT = 2,
  parameter int unsigned ADDR_BASE = ADDR_BASE_DEFAULT,
  parameter int unsigned SRAM_AW   = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n
);

  localparam int unsigned   CW       = (SRAM_WAIT > 0) ? $clog2(SRAM_WAIT + 1) : 1;
  localparam int unsigned   IW       = SRAM_AW - 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SRAM_WAIT);
  localparam logic [31:0]   BASE     = 32'(ADDR_BASE);

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic            op_wr;
  logic [IW-1:0]   word_idx;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic            req;
  logic            last;
  logic            half;

  assign req       = rd_en | wr_en;
  assign last      = (cnt == CNT_LAST);
  assign read_data = rdata;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state: DONE always returns to IDLE so a held request cannot restart.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req)  state_nxt = LO;
      LO:      if (last) state_nxt = HI;
      HI:      if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, wait counter and load-data capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      op_wr    <= 1'b0;
      word_idx <= '0;
      wdata    <= '0;
      rdata    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            op_wr    <= wr_en;
            word_idx <= IW'((address - BASE) >> 2);
            wdata    <= write_data;
            cnt      <= '0;
          end
        end
        LO, HI: begin
          if (last) begin
            cnt <= '0;
            if (!op_wr) begin
              if (state == LO) rdata[15:0]  <= sram_dq_in;
              else             rdata[31:16] <= sram_dq_in;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake and SRAM strobes; ready is forced high while reset is held.
  always_comb begin
    ready       = 1'b0;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_ce_n   = 1'b1;
    sram_oe_n   = 1'b1;
    sram_we_n   = 1'b1;
    half        = HALF_LO;
    unique case (state)
      IDLE: ready = ~req;
      DONE: ready = 1'b1;
      LO, HI: begin
        half      = (state == HI) ? HALF_HI : HALF_LO;
        sram_addr = {word_idx, half};
        sram_ce_n = 1'b0;
        if (op_wr) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = (state == HI) ? wdata[31:16] : wdata[15:0];
        end else begin
          sram_oe_n = 1'b0;
        end
      end
      default: ;
    endcase
    if (!rst) ready = 1'b1;
  end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Self-checking bench for mem_sram_ctrl (SRAM_WAIT = 2 and SRAM_WAIT = 0).
module tb_mem_sram_ctrl;

  localparam int unsigned W = 2;
  localparam int unsigned N = 2 * W + 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        rd_en = 1'b0, wr_en = 1'b0;
  logic [31:0] address = '0, write_data = '0, read_data;
  logic        ready, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;

  logic        rd_0 = 1'b0, wr_0 = 1'b0;
  logic [31:0] address_0 = '0, write_data_0 = '0, read_data_0;
  logic        ready_0, dq_oe_0, ce_n_0, oe_n_0, we_n_0;
  logic [17:0] sram_addr_0;
  logic [15:0] dq_out_0, dq_in_0;

  bit [15:0] sram  [0:262143];
  bit [15:0] sram0 [0:15];
  bit [15:0] ref_mem [int];

  int checks = 0;
  int errors = 0;
  logic [31:0] last_load = '0;

  always #5 clk = ~clk;

  mem_sram_ctrl #(.SRAM_WAIT(W), .ADDR_BASE(1024), .SRAM_AW(18)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n)
  );

  mem_sram_ctrl #(.SRAM_WAIT(0), .ADDR_BASE(1024), .SRAM_AW(18)) dut0 (
    .clk(clk), .rst(rst), .rd_en(rd_0), .wr_en(wr_0), .address(address_0),
    .write_data(write_data_0), .read_data(read_data_0), .ready(ready_0),
    .sram_addr(sram_addr_0), .sram_dq_out(dq_out_0), .sram_dq_oe(dq_oe_0),
    .sram_dq_in(dq_in_0), .sram_ce_n(ce_n_0), .sram_oe_n(oe_n_0),
    .sram_we_n(we_n_0)
  );

  // Asynchronous-read SRAM models with synchronous write.
  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? sram[sram_addr] : 16'h0;
  assign dq_in_0    = (!ce_n_0 && !oe_n_0) ? sram0[sram_addr_0[3:0]] : 16'h0;

  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) sram[sram_addr] <= sram_dq_out;
    if (!ce_n_0 && !we_n_0 && dq_oe_0) sram0[sram_addr_0[3:0]] <= dq_out_0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Low-half SRAM address for a byte address: word offset from base, times two.
  function automatic logic [17:0] half_addr(input logic [31:0] a);
    logic [31:0] w;
    w = ((a - 32'd1024) / 32'd4) % 32'd131072;
    return 18'(w * 32'd2);
  endfunction

  function automatic logic [15:0] ref_rd(input logic [17:0] h);
    if (ref_mem.exists(int'(h))) return ref_mem[int'(h)];
    return 16'h0;
  endfunction

  // One transaction on the W=2 instance, starting at posedge+1 (cycle 0).
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input bit hold, input logic [31:0] exp_rd);
    logic [17:0] h;
    bit lo, hi, act;
    h = half_addr(a);
    rd_en = rd; wr_en = wr; address = a; write_data = d;
    for (int k = 0; k <= int'(N); k++) begin
      @(negedge clk);
      lo  = (k >= 1) && (k <= int'(W) + 1);
      hi  = (k >= int'(W) + 2) && (k <= 2 * int'(W) + 2);
      act = lo || hi;
      chk("ready", {31'b0, ready}, {31'b0, k == int'(N)});
      chk("ce_n", {31'b0, sram_ce_n}, {31'b0, !act});
      chk("oe_n", {31'b0, sram_oe_n}, {31'b0, !(act && !wr)});
      chk("we_n", {31'b0, sram_we_n}, {31'b0, !(act && wr)});
      chk("dq_oe", {31'b0, sram_dq_oe}, {31'b0, act && wr});
      chk("sram_addr", {14'b0, sram_addr}, lo ? {14'b0, h} : hi ? {14'b0, h + 18'd1} : 32'h0);
      chk("dq_out", {16'b0, sram_dq_out},
          (act && wr) ? {16'b0, (lo ? d[15:0] : d[31:16])} : 32'h0);
      if (k == 0) chk("read_data_hold", read_data, last_load);
      if (k == int'(N)) begin
        if (!wr) last_load = exp_rd;
        chk("read_data", read_data, last_load);
      end
      @(posedge clk); #1;
      if (k == 0 && !hold) begin
        rd_en = 1'b0; wr_en = 1'b0; address = $urandom; write_data = $urandom;
      end
      if (k == int'(N)) begin
        rd_en = 1'b0; wr_en = 1'b0;
      end
    end
    if (wr) begin
      ref_mem[int'(h)]         = d[15:0];
      ref_mem[int'(h + 18'd1)] = d[31:16];
    end
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    bit          hold;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int cyc;
    bit saw_we;
    logic [31:0] a, d;
    logic [17:0] h;
    bit r;

    vecs[0] = '{1, 0, 32'h408, 32'h0,        0, 32'hDEADBEEF};
    vecs[1] = '{0, 1, 32'h400, 32'h12345678, 1, 32'h0};
    vecs[2] = '{1, 0, 32'h400, 32'h0,        0, 32'h12345678};
    vecs[3] = '{0, 1, 32'h3FC, 32'hA5A55A5A, 0, 32'h0};
    vecs[4] = '{1, 0, 32'h3FC, 32'h0,        1, 32'hA5A55A5A};
    vecs[5] = '{0, 1, 32'h40C, 32'hCAFEF00D, 0, 32'h0};
    vecs[6] = '{1, 0, 32'h40C, 32'h0,        0, 32'hCAFEF00D};

    sram[4] = 16'hBEEF; sram[5] = 16'hDEAD;
    ref_mem[4] = 16'hBEEF; ref_mem[5] = 16'hDEAD;
    sram0[0] = 16'h1111; sram0[1] = 16'h2222;

    // Reset state, with a request present to show ready is forced high.
    rd_en = 1'b1; address = 32'h408;
    #12;
    chk("rst_ready", {31'b0, ready}, 32'h1);
    chk("rst_ce_n", {31'b0, sram_ce_n}, 32'h1);
    chk("rst_read_data", read_data, 32'h0);
    chk("rst_addr", {14'b0, sram_addr}, 32'h0);
    rd_en = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Directed table, consecutive entries run back-to-back.
    foreach (vecs[i])
      run_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].hold, vecs[i].exp_rd);

    chk("sram_0", {16'b0, sram[0]}, 32'h5678);
    chk("sram_1", {16'b0, sram[1]}, 32'h1234);
    chk("sram_wrap_lo", {16'b0, sram[262142]}, 32'h5A5A);
    chk("sram_wrap_hi", {16'b0, sram[262143]}, 32'hA5A5);

    // Randomized traffic against the reference memory.
    for (int i = 0; i < 40; i++) begin
      r = 1'($urandom_range(0, 1));
      a = 32'h400 + 32'd4 * 32'($urandom_range(0, 63));
      d = $urandom;
      h = half_addr(a);
      run_txn(r, !r, a, d, 1'($urandom_range(0, 1)), {ref_rd(h + 18'd1), ref_rd(h)});
    end

    // Reset in the first HI cycle of a read.
    rd_en = 1'b1; address = 32'h408;
    repeat (W + 2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_ce_n", {31'b0, sram_ce_n}, 32'h1);
    chk("mid_rst_oe_n", {31'b0, sram_oe_n}, 32'h1);
    chk("mid_rst_ready", {31'b0, ready}, 32'h1);
    chk("mid_rst_read_data", read_data, 32'h0);
    last_load = '0;
    @(negedge clk); rd_en = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    run_txn(1, 0, 32'h408, 32'h0, 1, 32'hDEADBEEF);
    @(negedge clk);
    chk("idle_ready", {31'b0, ready}, 32'h1);
    chk("idle_ce_n", {31'b0, sram_ce_n}, 32'h1);

    // SRAM_WAIT = 0: read, then simultaneous read/write request.
    @(posedge clk); #1;
    rd_0 = 1'b1; address_0 = 32'h400;
    cyc = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ready_0) break;
      cyc++;
    end
    chk("w0_read_latency", 32'(cyc), 32'd3);
    chk("w0_read_data", read_data_0, 32'h22221111);
    @(posedge clk); #1;
    rd_0 = 1'b0;
    @(posedge clk); #1;
    rd_0 = 1'b1; wr_0 = 1'b1; address_0 = 32'h404; write_data_0 = 32'h9ABCDEF0;
    cyc = 0; saw_we = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!we_n_0) saw_we = 1'b1;
      if (ready_0) break;
      cyc++;
    end
    chk("w0_write_latency", 32'(cyc), 32'd3);
    chk("w0_write_prio", {31'b0, saw_we}, 32'h1);
    chk("w0_read_data_kept", read_data_0, 32'h22221111);
    @(posedge clk); #1;
    rd_0 = 1'b0; wr_0 = 1'b0;
    @(negedge clk);
    chk("w0_sram_2", {16'b0, sram0[2]}, 32'hDEF0);
    chk("w0_sram_3", {16'b0, sram0[3]}, 32'h9ABC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
